// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } loader_state_e;

  localparam int IMEM_DEPTH = 4096;
  localparam int WORD_BYTES = 4;
  localparam int WORD_BITS  = 8 * WORD_BYTES;
  localparam int IDX_W      = $clog2(WORD_BYTES);

endpackage

// File: rtl/imem_word_packer.sv
// Assembles little-endian bytes into one instruction word; word_full_o is
// high for the single cycle after the last byte of a word was taken.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 accept_i,
  input  logic [7:0]           byte_i,
  output logic                 last_byte_o,
  output logic                 word_full_o,
  output logic [WORD_BITS-1:0] word_o
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             word_full_q, word_full_d;

  always_comb begin
    idx_d       = idx_q;
    word_full_d = 1'b0;
    if (clear_i) begin
      idx_d = '0;
    end else if (accept_i) begin
      idx_d       = idx_q + 1'b1;
      word_full_d = (idx_q == IDX_W'(WORD_BYTES - 1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q       <= '0;
      word_full_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      word_full_q <= word_full_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      logic [7:0] lane_q;
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          lane_q <= '0;
        end else if (accept_i && !clear_i && (idx_q == IDX_W'(gi))) begin
          lane_q <= byte_i;
        end
      end
      assign word_o[8*gi +: 8] = lane_q;
    end
  endgenerate

  assign last_byte_o = (idx_q == IDX_W'(WORD_BYTES - 1));
  assign word_full_o = word_full_q;

endmodule

// File: rtl/imem_loader.sv
// Streams bytes from an upstream source into instruction memory, one word
// write per four accepted bytes, while holding the core in reset via busy.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_DEPTH  = IMEM_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-2:0] num_words,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  writeEnable,
  output logic [ADDR_WIDTH-1:0] writeAddress,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CW = ADDR_WIDTH - 1;

  loader_state_e         state_q, state_d;
  logic [CW-1:0]         count_q, count_d, count_inc;
  logic [CW-1:0]         num_q, num_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, addr_now;
  logic [WORD_BITS-1:0]  wdata_q, wdata_d, word;
  logic                  clear, accept, last_byte, word_full, too_big;
  logic                  in_write;

  assign accept    = byte_valid && (state_q == ST_COLLECT);
  assign in_write  = (state_q == ST_WRITE);
  assign addr_now  = {count_q[ADDR_WIDTH-3:0], 2'b00};
  assign count_inc = count_q + CW'(1);
  assign too_big   = (int'(num_words) * WORD_BYTES) > MEM_DEPTH;

  imem_word_packer u_packer (
    .clk_i       (clock),
    .rst_ni      (reset),
    .clear_i     (clear),
    .accept_i    (accept),
    .byte_i      (byte_data),
    .last_byte_o (last_byte),
    .word_full_o (word_full),
    .word_o      (word)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    num_d   = num_q;
    error_d = error_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          num_d   = num_words;
          count_d = '0;
          error_d = 1'b0;
          clear   = 1'b1;
          if (num_words == '0) begin
            state_d = ST_DONE;
          end else if (too_big) begin
            error_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        if (accept && last_byte) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        waddr_d = addr_now;
        wdata_d = word;
        count_d = count_inc;
        state_d = (count_inc == num_q) ? ST_DONE : ST_COLLECT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      num_q   <= '0;
      error_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      num_q   <= num_d;
      error_q <= error_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Reset gates the strobe combinationally so a write in flight is dropped.
  assign writeEnable  = in_write && word_full && reset;
  assign writeAddress = in_write ? addr_now : waddr_q;
  assign writeData    = DATA_WIDTH'(in_write ? word : wdata_q);
  assign byte_ready   = (state_q == ST_COLLECT);
  assign busy         = (state_q == ST_COLLECT) || in_write;
  assign done         = (state_q == ST_DONE);
  assign error        = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a word-level model predicts every write.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] num_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        writeEnable;
  logic [11:0] writeAddress;
  logic [31:0] writeData;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .num_words    (num_words),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .writeEnable  (writeEnable),
    .writeAddress (writeAddress),
    .writeData    (writeData),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks  = 0;
  int          n_errors  = 0;
  int          n_writes  = 0;
  logic [11:0] last_addr = '0;
  bit          tog       = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every observed write must match the oldest word the model expects.
  initial begin
    wr_t e;
    forever begin
      @(negedge clock);
      if (writeEnable === 1'b1) begin
        n_writes++;
        last_addr = writeAddress;
        if (exp_q.size() == 0) begin
          check_val("spurious_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("wr_addr", writeAddress, e.addr);
          check_val("wr_data", writeData, e.data);
          $display("write addr=0x%03h data=0x%08h", writeAddress, writeData);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input int mode);
    bit stall;
    bit taken = 1'b0;
    int guard = 0;
    while (!taken) begin
      tog = ~tog;
      stall = (mode == 1) ? tog : (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (stall) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_data  = b;
        taken      = (byte_ready === 1'b1);
      end
      @(negedge clock);
      guard++;
      if (guard > 64) begin
        check_val("byte_timeout", 1, 0);
        return;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_ready"}, byte_ready, 0);
    check_val({tag, "_we"}, writeEnable, 0);
    check_val({tag, "_addr"}, writeAddress, 0);
    check_val({tag, "_data"}, writeData, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_error"}, error, 0);
  endtask

  task automatic do_load(input int n, input int mode, input bit fixed,
                         input logic [31:0] fw, input bit poke_start);
    int          w0 = n_writes;
    logic [31:0] word;
    @(negedge clock);
    start     = 1'b1;
    num_words = 11'(n);
    @(negedge clock);
    start = 1'b0;
    if (n == 0 || n * 4 > 4096) begin
      check_val("done_early", done, 1);
      check_val("error_flag", error, (n != 0));
      check_val("busy_early", busy, 0);
      repeat (3) @(negedge clock);
      check_val("no_write", n_writes - w0, 0);
      check_val("done_hold", done, 1);
      $display("load n=%0d done=%b error=%b writes=%0d", n, done, error, n_writes - w0);
      return;
    end
    check_val("busy_start", busy, 1);
    for (int w = 0; w < n; w++) begin
      word = fixed ? fw : $urandom;
      exp_q.push_back('{addr: 12'(w * 4), data: word});
      check_val("ready_word", byte_ready, 1);
      for (int b = 0; b < 4; b++) begin
        if (poke_start && w == 0 && b == 2) begin
          start      = 1'b1;
          num_words  = '0;
          byte_valid = 1'b0;
          @(negedge clock);
          start = 1'b0;
          check_val("start_ignored", busy, 1);
        end
        send_byte(word[8*b +: 8], mode);
      end
      check_val("wr_latency", writeEnable, 1);
      check_val("ready_in_write", byte_ready, 0);
      // Offer a junk byte during the write cycle; it must not be taken.
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      @(negedge clock);
    end
    byte_valid = 1'b0;
    check_val("done_end", done, 1);
    check_val("busy_end", busy, 0);
    check_val("error_end", error, 0);
    repeat (2) @(negedge clock);
    check_val("done_stable", done, 1);
    check_val("write_count", n_writes - w0, n);
    $display("load n=%0d mode=%0d writes=%0d done=%b error=%b", n, mode, n_writes - w0, done, error);
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    num_words  = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset = 1'b1;

    do_load(1, 0, 1'b1, 32'h0000_0013, 1'b0);
    do_load(3, 1, 1'b0, '0, 1'b0);
    do_load(0, 0, 1'b0, '0, 1'b0);
    do_load(1024, 2, 1'b0, '0, 1'b0);
    check_val("last_addr", last_addr, 12'hFFC);
    do_load(1025, 0, 1'b0, '0, 1'b0);
    do_load(2, 0, 1'b0, '0, 1'b1);

    // Abort a load after two bytes of the first word.
    @(negedge clock);
    start     = 1'b1;
    num_words = 11'd2;
    @(negedge clock);
    start = 1'b0;
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 0);
    reset      = 1'b0;
    byte_valid = 1'b0;
    @(negedge clock);
    check_idle_outputs("abort");
    $display("abort after 2 bytes: busy=%b we=%b", busy, writeEnable);
    reset = 1'b1;
    do_load(1, 0, 1'b0, '0, 1'b0);

    repeat (4) do_load($urandom_range(1, 6), $urandom_range(0, 2), 1'b0, '0, 1'b0);

    check_val("pending_writes", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
